// File: rtl/rotary_encoder_pkg.sv
// Shared types and helpers for the multi-channel quadrature encoder decoder.
// Holds the detent FSM state encoding, the rest code and the position adder.
package rotary_encoder_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CW1    = 3'd1,
        CW2    = 3'd2,
        CW3    = 3'd3,
        CCW1   = 3'd4,
        CCW2   = 3'd5,
        CCW3   = 3'd6,
        RESYNC = 3'd7
    } enc_state_t;

    localparam logic [1:0] REST_AB = 2'b11;

    // Result is exact in 64 bits; the caller keeps the low width bits, which
    // gives modular wrap when sat is clear.
    function automatic logic signed [63:0] pos_add(
        input logic signed [63:0] cur,
        input logic signed [63:0] delta,
        input int                 width,
        input logic               sat
    );
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = cur + delta;
        hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (width - 1));
        if (sat && (sum > hi)) begin
            sum = hi;
        end else if (sat && (sum < lo)) begin
            sum = lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/rotary_encoder_ch.sv
// One encoder channel: synchroniser, tick-sampled debouncer, detent FSM and
// position counter. ROTARY_ENCODER_MC_ACCEL_EN adds same-direction acceleration.
//
// state  | meaning
// IDLE   | resting at detent (AB=11)
// CW1    | CW step 1 seen (AB=01)
// CW2    | CW step 2 seen (AB=00)
// CW3    | CW step 3 seen (AB=10)
// CCW1   | CCW step 1 seen (AB=10)
// CCW2   | CCW step 2 seen (AB=00)
// CCW3   | CCW step 3 seen (AB=01)
// RESYNC | illegal jump seen, waiting for AB=11
import rotary_encoder_pkg::*;

module rotary_encoder_ch #(
    parameter int DEBOUNCE   = 3,
    parameter int CNT_W      = 16,
    parameter int SAT        = 0,
    parameter int ACCEL_WIN  = 40,
    parameter int ACCEL_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             a,
    input  logic             b,
    input  logic             pos_clr,
    output logic             pul_inc,
    output logic             pul_dec,
    output logic             err,
    output logic [CNT_W-1:0] pos
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);

    logic [1:0]              sync1;
    logic [1:0]              sync2;
    logic [1:0]              ab_deb;
    logic [DB_W-1:0]         stab_cnt;
    logic                    deb_chg;
    logic                    deb_flip;
    enc_state_t              state;
    logic signed [CNT_W-1:0] pos_q;
    logic signed [CNT_W-1:0] pos_nxt;
    logic signed [63:0]      step;
    logic signed [63:0]      delta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= {a, b};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ab_deb   <= REST_AB;
            stab_cnt <= '0;
            deb_chg  <= 1'b0;
            deb_flip <= 1'b0;
        end else begin
            deb_chg  <= 1'b0;
            deb_flip <= 1'b0;
            if (tick) begin
                if (sync2 != ab_deb) begin
                    if (stab_cnt == DB_W'(DEBOUNCE - 1)) begin
                        ab_deb   <= sync2;
                        stab_cnt <= '0;
                        deb_chg  <= 1'b1;
                        deb_flip <= ((sync2 ^ ab_deb) == 2'b11);
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                    end
                end else begin
                    stab_cnt <= '0;
                end
            end
        end
    end

    // Acts on the cycle after a debounced change; ab_deb already holds the new code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pul_inc <= 1'b0;
            pul_dec <= 1'b0;
            err     <= 1'b0;
        end else begin
            pul_inc <= 1'b0;
            pul_dec <= 1'b0;
            err     <= deb_chg & deb_flip;
            if (deb_chg) begin
                if (state == RESYNC) begin
                    if (ab_deb == REST_AB) state <= IDLE;
                end else if (deb_flip) begin
                    state <= RESYNC;
                end else begin
                    case (state)
                        IDLE: state <= (ab_deb == 2'b01) ? CW1 : CCW1;
                        CW1:  state <= (ab_deb == 2'b00) ? CW2 : IDLE;
                        CW2:  state <= (ab_deb == 2'b10) ? CW3 : CW1;
                        CW3: begin
                            if (ab_deb == REST_AB) begin
                                state   <= IDLE;
                                pul_inc <= 1'b1;
                            end else begin
                                state <= CW2;
                            end
                        end
                        CCW1: state <= (ab_deb == 2'b00) ? CCW2 : IDLE;
                        CCW2: state <= (ab_deb == 2'b01) ? CCW3 : CCW1;
                        CCW3: begin
                            if (ab_deb == REST_AB) begin
                                state   <= IDLE;
                                pul_dec <= 1'b1;
                            end else begin
                                state <= CCW2;
                            end
                        end
                        default: state <= RESYNC;
                    endcase
                end
            end
        end
    end

`ifdef ROTARY_ENCODER_MC_ACCEL_EN
    localparam int GAP_W = $clog2(ACCEL_WIN + 1);

    logic [GAP_W-1:0] gap;
    logic             last_inc;
    logic             have_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap       <= '0;
            last_inc  <= 1'b0;
            have_prev <= 1'b0;
        end else if (pul_inc | pul_dec) begin
            gap       <= '0;
            last_inc  <= pul_inc;
            have_prev <= 1'b1;
        end else if (tick && (gap != GAP_W'(ACCEL_WIN))) begin
            gap <= gap + 1'b1;
        end
    end

    assign step = (have_prev && (last_inc == pul_inc) && (gap < GAP_W'(ACCEL_WIN)))
                  ? 64'(ACCEL_STEP) : 64'sd1;
`else
    // Without acceleration the step is always one; the window/step values are inert.
    localparam int FIXED_STEP = (ACCEL_WIN >= 0 && ACCEL_STEP >= 0) ? 1 : 1;

    assign step = 64'(FIXED_STEP);
`endif

    always_comb begin
        delta   = pul_inc ? step : -step;
        pos_nxt = CNT_W'(pos_add(64'(pos_q), delta, CNT_W, SAT != 0));
    end

    // Position follows the registered pulse by one cycle so a clear in the pulse cycle wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_q <= '0;
        end else if (pos_clr) begin
            pos_q <= '0;
        end else if (pul_inc | pul_dec) begin
            pos_q <= pos_nxt;
        end
    end

    assign pos = pos_q;

endmodule

// File: rtl/rotary_encoder_mc.sv
// Multi-channel quadrature encoder decoder: shared sample-tick prescaler plus
// NCH independent channels. Optional acceleration via ROTARY_ENCODER_MC_ACCEL_EN.
module rotary_encoder_mc #(
    parameter int NCH        = 2,
    parameter int CLK_DIV    = 125000,
    parameter int DEBOUNCE   = 3,
    parameter int CNT_W      = 16,
    parameter int SAT        = 0,
    parameter int ACCEL_WIN  = 40,
    parameter int ACCEL_STEP = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       data_a,
    input  logic [NCH-1:0]       data_b,
    input  logic [NCH-1:0]       pos_clr,
    output logic [NCH-1:0]       pul_inc,
    output logic [NCH-1:0]       pul_dec,
    output logic [NCH-1:0]       err,
    output logic [NCH*CNT_W-1:0] pos,
    output logic                 tick_1k
);

    localparam int PS_W = $clog2(CLK_DIV);

    logic [PS_W-1:0] ps_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_cnt <= '0;
        end else if (tick_1k) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    assign tick_1k = (ps_cnt == PS_W'(CLK_DIV - 1));

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        rotary_encoder_ch #(
            .DEBOUNCE   (DEBOUNCE),
            .CNT_W      (CNT_W),
            .SAT        (SAT),
            .ACCEL_WIN  (ACCEL_WIN),
            .ACCEL_STEP (ACCEL_STEP)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick_1k),
            .a       (data_a[i]),
            .b       (data_b[i]),
            .pos_clr (pos_clr[i]),
            .pul_inc (pul_inc[i]),
            .pul_dec (pul_dec[i]),
            .err     (err[i]),
            .pos     (pos[i*CNT_W +: CNT_W])
        );
    end

endmodule
